// File: rtl/fp_norm_pack_if.sv
// Start/done handshake and data bundle between the fpadd front end and the
// normalise/round/pack back end.
interface fp_norm_pack_if #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 10
);
  // start is a one-cycle request, taken only while busy is low; done then
  // stays high with result/flags stable until the next taken start.
  logic              start;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [31:0]       result;
  logic              done;
  logic              busy;
  logic              overflow;
  logic              inexact;

  modport master (
    output start, in_sign, in_exp, in_mant,
    input  result, done, busy, overflow, inexact
  );

  modport slave (
    input  start, in_sign, in_exp, in_mant,
    output result, done, busy, overflow, inexact
  );
endinterface

// File: rtl/fp_norm_pack.sv
// Iterative normaliser, round-to-nearest-even and binary32 packer for the
// single-precision add path; one shift per clock.
module fp_norm_pack #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 10
) (
  input  logic                clk,
  input  logic                reset,
  fp_norm_pack_if.slave       bus,
  output logic [2:0]          dbg_state_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ROUND = 3'd2,
    S_PACK  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic signed [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_MAX = EXP_W'(255);

  state_t                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  logic                     renorm_q, renorm_d;
  logic [31:0]              result_q, result_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic                     overflow_q, overflow_d;
  logic                     inexact_q, inexact_d;

  logic [MANT_W-1:0]        mant_rsh;
  logic [MANT_W-3:0]        mant_up;
  logic                     rnd_l, rnd_g, rnd_s;

  // Right shift that folds the dropped bit into sticky.
  assign mant_rsh = {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
  assign mant_up  = mant_q[MANT_W-1:2] + (MANT_W-2)'(1);
  assign rnd_l    = mant_q[2];
  assign rnd_g    = mant_q[1];
  assign rnd_s    = mant_q[0];

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mant_d     = mant_q;
    renorm_d   = renorm_q;
    result_d   = result_q;
    done_d     = done_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          sign_d     = bus.in_sign;
          exp_d      = bus.in_exp;
          mant_d     = bus.in_mant;
          renorm_d   = 1'b0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q == '0) begin
          state_d = S_ROUND;
        end else if (mant_q[MANT_W-1]) begin
          mant_d = mant_rsh;
          exp_d  = exp_q + EXP_ONE;
          // A rounding carry-out needs exactly this one shift before re-rounding.
          if (renorm_q) begin
            renorm_d = 1'b0;
            state_d  = S_ROUND;
          end
        end else if (exp_q < EXP_ONE && mant_q[MANT_W-1:1] == '0) begin
          exp_d = EXP_ONE;
        end else if (exp_q < EXP_ONE) begin
          mant_d = mant_rsh;
          exp_d  = exp_q + EXP_ONE;
        end else if (!mant_q[MANT_W-2] && exp_q > EXP_ONE) begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        inexact_d = inexact_q | rnd_g | rnd_s;
        state_d   = S_PACK;
        if (rnd_g && (rnd_s || rnd_l)) begin
          mant_d = {mant_up, 2'b00};
          if (mant_up[MANT_W-3]) begin
            renorm_d = 1'b1;
            state_d  = S_NORM;
          end
        end
      end
      S_PACK: begin
        if (exp_q >= EXP_MAX) begin
          result_d   = {sign_q, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else if (mant_q == '0) begin
          result_d = {sign_q, 31'd0};
        end else if (!mant_q[MANT_W-2]) begin
          result_d = {sign_q, 8'h00, mant_q[MANT_W-3:2]};
        end else begin
          result_d = {sign_q, exp_q[7:0], mant_q[MANT_W-3:2]};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      renorm_q   <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      mant_q     <= mant_d;
      renorm_q   <= renorm_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.inexact  = inexact_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_fp_norm_pack.sv
// Directed plus randomized checks of fp_norm_pack against an arithmetic
// reference model of normalise / round-nearest-even / pack.
module tb_fp_norm_pack;
  localparam int MANT_W = 27;
  localparam int EXP_W  = 10;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  int         n_vec;
  int         n_err;

  fp_norm_pack_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();

  fp_norm_pack #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: value-level normalise, round-to-nearest-even, pack; also
  // counts the clocks the iterative unit should spend.
  function automatic void ref_model(input bit s, input int e_in, input int m_in,
                                    output logic [31:0] res, output bit ovf,
                                    output bit inx, output int lat);
    longint m;
    int     e;
    bit     go, g, st, l;
    logic [7:0]  e8;
    logic [22:0] frac;
    m = m_in; e = e_in; lat = 3; ovf = 0; go = 1;
    while (go) begin
      if (m == 0) go = 0;
      else if (m >= (64'd1 << 26)) begin m = (m >> 1) | (m & 1); e++; lat++; end
      else if (e < 1 && m < 2) begin e = 1; lat++; end
      else if (e < 1) begin m = (m >> 1) | (m & 1); e++; lat++; end
      else if (m < (64'd1 << 25) && e > 1) begin m = m * 2; e--; lat++; end
      else go = 0;
    end
    g = m[1]; st = m[0]; l = m[2];
    inx = g | st;
    if (g && (st || l)) begin
      m = ((m >> 2) + 1) * 4;
      if (m >= (64'd1 << 26)) begin m = m >> 1; e++; lat += 2; end
    end
    e8 = e[7:0];
    frac = m[24:2];
    if (e >= 255) begin res = {s, 8'hFF, 23'd0}; ovf = 1; end
    else if (m == 0) res = {s, 31'd0};
    else if (m < (64'd1 << 25)) res = {s, 8'h00, frac};
    else res = {s, e8, frac};
  endfunction

  task automatic drive_start(input bit s, input int e, input int m);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.in_sign = s;
    bus.in_exp  = EXP_W'(e);
    bus.in_mant = MANT_W'(m);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // One operation; poke > 0 pulses a conflicting start that many cycles in.
  task automatic run_op(input bit s, input int e, input int m, input int poke);
    logic [31:0] exp_res;
    bit          exp_ovf, exp_inx;
    int          exp_lat, k;
    bit          seen;
    ref_model(s, e, m, exp_res, exp_ovf, exp_inx, exp_lat);
    drive_start(s, e, m);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_cleared", 32'(bus.done), 32'd0);
    k = 1; seen = 0;
    while (!seen && k <= 300) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1;
      else begin
        k++;
        if (k == poke) begin
          bus.start = 1'b1; bus.in_sign = ~s; bus.in_exp = EXP_W'(127);
          bus.in_mant = MANT_W'(32'h2000000);
        end else bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      n_vec++; n_err++;
      $error("FAIL timeout observed=no_done expected=done_after_%0d", exp_lat);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      check("result", bus.result, exp_res);
      check("overflow", 32'(bus.overflow), 32'(exp_ovf));
      check("inexact", 32'(bus.inexact), 32'(exp_inx));
      check("busy_at_done", 32'(bus.busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("result_hold", bus.result, exp_res);
      check("done_hold", 32'(bus.done), 32'd1);
    end
  endtask

  initial begin
    int e, m, sel;
    n_vec = 0; n_err = 0;
    bus.start = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", bus.result, 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(0, 127, 32'h2000000, 0);
    run_op(0, 127, 32'h4000000, 0);
    run_op(0, 127, 32'h0000004, 0);
    run_op(0, 127, 32'h2000002, 0);
    run_op(0, 127, 32'h2000006, 0);
    run_op(0, 127, 32'h3FFFFFE, 0);
    run_op(0, 254, 32'h4000000, 0);
    run_op(1, 127, 32'h0000000, 0);
    run_op(0, -1,  32'h2000000, 0);
    run_op(1, -5,  32'h0000001, 0);
    run_op(0, 1,   32'h1FFFFFE, 0);
    run_op(0, 254, 32'h3FFFFFF, 0);
    // conflicting start mid-normalisation must be ignored
    run_op(0, 127, 32'h0000004, 5);

    // reset asserted mid-normalisation clears everything at the next edge
    drive_start(0, 127, 32'h0000004);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_result", bus.result, 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_flags", {30'd0, bus.overflow, bus.inexact}, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(0, 127, 32'h2000000, 0);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 3);
      e = $urandom_range(0, 300) - 40;
      case (sel)
        0: m = $urandom_range(0, 32'h7FFFFFF);
        1: m = $urandom_range(0, 255);
        2: m = 32'h2000000 | $urandom_range(0, 32'h1FFFFFF);
        default: m = 32'h3FFFFF8 | $urandom_range(0, 7);
      endcase
      run_op(1'($urandom_range(0, 1)), e, m, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
